// File: rtl/fetch_prefetch_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_prefetch_queue_if : redirect, imem req/gnt/rvalid and IF/ID bus     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface fetch_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc4;
  logic [CW-1:0] fifo_count;

  // The fetch unit: issues memory requests and sources the instruction stream.
  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4, fifo_count
  );

  // The environment: branch resolution, instruction memory and IF/ID.
  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_prefetch_queue : single-outstanding instruction prefetch into a    |
// | {pc, instr} FIFO with flush-on-redirect.   Revision 1.0                  |
// +--------------------------------------------------------------------------+
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_prefetch_queue_if.master bus_io
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic          out_valid_w;
  logic          push_w;
  logic          pop_w;
  logic          space_w;
  logic [31:0]   redirect_tgt_w;

  always_comb begin
    redirect_tgt_w = bus_io.redirect_pc & 32'hFFFF_FFFC;
    out_valid_w    = (count_q != '0) && !bus_io.redirect_valid && !reset;
    pop_w          = out_valid_w && bus_io.out_ready;
    push_w         = (state_q == ST_WAIT) && bus_io.imem_rvalid && !discard_q && !bus_io.redirect_valid;
    if (bus_io.redirect_valid) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push_w) - CW'(pop_w);
    end
    // A new request is only issued when its response is guaranteed a slot.
    space_w = count_d < CW'(DEPTH);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.redirect_valid) fetch_pc_d = redirect_tgt_w;
        if (space_w) state_d = ST_REQ;
      end
      ST_REQ: begin
        // discard_q here means a redirect already replaced fetch_pc while this request was held.
        if (bus_io.redirect_valid) begin
          fetch_pc_d = redirect_tgt_w;
          discard_d  = 1'b1;
        end else if (bus_io.imem_gnt && !discard_q) begin
          fetch_pc_d = addr_q + 32'd4;
        end
        if (bus_io.imem_gnt) begin
          req_pc_d = addr_q;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus_io.redirect_valid) fetch_pc_d = redirect_tgt_w;
        if (bus_io.imem_rvalid) begin
          discard_d = 1'b0;
          state_d   = space_w ? ST_REQ : ST_IDLE;
        end else if (bus_io.redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = ST_REQ;
    endcase
    if (state_d == ST_REQ && state_q != ST_REQ) addr_d = fetch_pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_pc_q   <= '0;
      discard_q  <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      if (bus_io.redirect_valid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_w) begin
      instr_q[wr_ptr_q] <= bus_io.imem_rdata;
      pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign bus_io.imem_req   = (state_q == ST_REQ) && !reset;
  assign bus_io.imem_addr  = addr_q;
  assign bus_io.out_valid  = out_valid_w;
  assign bus_io.out_instr  = instr_q[rd_ptr_q];
  assign bus_io.out_pc     = pc_q[rd_ptr_q];
  assign bus_io.out_pc4    = pc_q[rd_ptr_q] + 32'd4;
  assign bus_io.fifo_count = reset ? '0 : count_q;

endmodule
`default_nettype wire
